// File: rtl/bird_physics.sv
// Vertical-motion engine for the Flappy Bird bird: timed rise after each flap,
// gravity otherwise, with ceiling, floor and pipe-collision detection.
module bird_physics #(
    parameter int unsigned ROWS      = 16,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned FLAP_RISE = 3,
    parameter int unsigned START_ROW = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flap,
    input  logic                    collide,
    output logic [$clog2(ROWS)-1:0] bird_row,
    output logic                    playing,
    output logic                    game_over,
    output logic                    tick
);

    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned TCNT_W = $clog2(TICK_DIV);
    localparam int unsigned RISE_W = $clog2(FLAP_RISE + 1);

    localparam logic [ROW_W-1:0]  ROW_START = ROW_W'(START_ROW);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_DIV - 1);
    localparam logic [RISE_W-1:0] RISE_MAX  = RISE_W'(FLAP_RISE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t              r_state;
    logic [ROW_W-1:0]    r_row;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [RISE_W-1:0]   r_rise;

    logic                w_tick;
    logic [RISE_W-1:0]   w_rise_eff;

    assign w_tick     = (r_state == FLY) && (r_tcnt == TCNT_LAST);
    // A flap landing on the tick cycle takes effect on that very step.
    assign w_rise_eff = flap ? RISE_MAX : r_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_row   <= ROW_START;
            r_tcnt  <= '0;
            r_rise  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_row <= ROW_START;
                    if (flap) begin
                        r_state <= FLY;
                        r_rise  <= RISE_MAX;
                        r_tcnt  <= '0;
                    end
                end
                FLY: begin
                    if (collide) begin
                        r_state <= DEAD;
                    end else begin
                        r_tcnt <= w_tick ? '0 : r_tcnt + TCNT_W'(1);
                        // Bounds are tested before the update so the row never wraps.
                        if (w_tick) begin
                            if (w_rise_eff != '0) begin
                                if (r_row == '0) begin
                                    r_state <= DEAD;
                                end else begin
                                    r_row  <= r_row - ROW_W'(1);
                                    r_rise <= w_rise_eff - RISE_W'(1);
                                end
                            end else if (r_row == ROW_LAST) begin
                                r_state <= DEAD;
                            end else begin
                                r_row <= r_row + ROW_W'(1);
                            end
                        end else if (flap) begin
                            r_rise <= RISE_MAX;
                        end
                    end
                end
                DEAD: begin
                    r_state <= DEAD;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bird_row  = r_row;
    assign playing   = (r_state == FLY);
    assign game_over = (r_state == DEAD);
    assign tick      = w_tick;

endmodule

// File: tb/tb_bird_physics.sv
// Directed bench for bird_physics: reset, rise/fall, reload, ceiling, floor,
// collision and reset-recovery with hand-computed rows.
module tb_bird_physics;

    logic       clk;
    logic       reset;
    logic       flap;
    logic       collide;
    logic [3:0] bird_row;
    logic       playing;
    logic       game_over;
    logic       tick;

    int n_pass  = 0;
    int n_total = 0;

    bird_physics #(
        .ROWS      (16),
        .TICK_DIV  (4),
        .FLAP_RISE (3),
        .START_ROW (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flap      (flap),
        .collide   (collide),
        .bird_row  (bird_row),
        .playing   (playing),
        .game_over (game_over),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input int row, input bit play, input bit go);
        chk({tag, ".row"}, 32'(bird_row), 32'(row));
        chk({tag, ".playing"}, 32'(playing), 32'(play));
        chk({tag, ".game_over"}, 32'(game_over), 32'(go));
    endtask

    // One clock; inputs applied before the edge, outputs sampled 1 time unit after it.
    task automatic step(input bit f, input bit c);
        flap    = f;
        collide = c;
        @(posedge clk);
        #1;
        flap    = 1'b0;
        collide = 1'b0;
    endtask

    // Entry phase: tcnt==0. Edge 4 is the tick edge; fa/ca select which edge sees flap/collide.
    task automatic tstep(input string tag, input int fa, input int ca,
                         input int row, input bit play, input bit go);
        for (int k = 1; k <= 4; k++) begin
            step(fa == k, ca == k);
            chk($sformatf("%s.tick%0d", tag, k), 32'(tick), 32'(k == 3));
        end
        chk_state(tag, row, play, go);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic start_fly(input string tag);
        step(1'b1, 1'b0);
        chk_state(tag, 8, 1'b1, 1'b0);
        chk({tag, ".tick"}, 32'(tick), 32'(0));
    endtask

    task automatic dead_hold(input string tag, input int row, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk({tag, ".tick"}, 32'(tick), 32'(0));
            chk_state(tag, row, 1'b0, 1'b1);
        end
    endtask

    initial begin
        reset   = 1'b1;
        flap    = 1'b0;
        collide = 1'b0;

        // Reset and idle: collide pulses must be ignored, no ticks.
        do_reset(2);
        chk_state("reset", 8, 1'b0, 1'b0);
        chk("reset.tick", 32'(tick), 32'(0));
        for (int i = 0; i < 20; i++) begin
            step(1'b0, (i % 5) == 2);
            chk("idle.tick", 32'(tick), 32'(0));
            chk_state("idle", 8, 1'b0, 1'b0);
        end

        // Single flap: up 3, then fall to the floor and die there.
        start_fly("flap1");
        tstep("s2.r7", 0, 0, 7, 1'b1, 1'b0);
        tstep("s2.r6", 0, 0, 6, 1'b1, 1'b0);
        tstep("s2.r5", 0, 0, 5, 1'b1, 1'b0);
        for (int r = 6; r <= 15; r++)
            tstep($sformatf("s2.r%0d", r), 0, 0, r, 1'b1, 1'b0);
        tstep("s2.floor", 0, 0, 15, 1'b0, 1'b1);
        dead_hold("s2.dead", 15, 6);

        // Reload (no accumulation), flap on the tick, then ceiling death.
        do_reset(1);
        chk_state("s3.reset", 8, 1'b0, 1'b0);
        start_fly("flap3");
        tstep("s3.r7", 0, 0, 7, 1'b1, 1'b0);
        tstep("s3.r6", 0, 0, 6, 1'b1, 1'b0);
        tstep("s3.reload", 2, 0, 5, 1'b1, 1'b0);
        tstep("s3.fliptick", 4, 0, 4, 1'b1, 1'b0);
        tstep("s3.r3", 0, 0, 3, 1'b1, 1'b0);
        tstep("s3.r2", 0, 0, 2, 1'b1, 1'b0);
        tstep("s3.fall3", 0, 0, 3, 1'b1, 1'b0);
        tstep("s4.r2", 2, 0, 2, 1'b1, 1'b0);
        tstep("s4.r1", 0, 0, 1, 1'b1, 1'b0);
        tstep("s4.r0", 2, 0, 0, 1'b1, 1'b0);
        tstep("s4.ceiling", 0, 0, 0, 1'b0, 1'b1);
        dead_hold("s4.dead", 0, 6);

        // Collision coincident with tick and flap: no movement, frozen.
        do_reset(1);
        start_fly("flap5");
        tstep("s5.r7", 0, 0, 7, 1'b1, 1'b0);
        tstep("s5.collide", 4, 4, 7, 1'b0, 1'b1);
        dead_hold("s5.dead", 7, 10);

        // Reset from DEAD, restart, then reset in FLY at row 11.
        do_reset(1);
        chk_state("s6.rdead", 8, 1'b0, 1'b0);
        chk("s6.rdead.tick", 32'(tick), 32'(0));
        start_fly("flap6");
        tstep("s6.r7", 0, 0, 7, 1'b1, 1'b0);
        tstep("s6.r6", 0, 0, 6, 1'b1, 1'b0);
        tstep("s6.r5", 0, 0, 5, 1'b1, 1'b0);
        for (int r = 6; r <= 11; r++)
            tstep($sformatf("s6.r%0d", r), 0, 0, r, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        chk_state("s6.rfly", 8, 1'b0, 1'b0);
        chk("s6.rfly.tick", 32'(tick), 32'(0));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            chk("s6.idle.tick", 32'(tick), 32'(0));
        end
        start_fly("flap7");
        tstep("s6.again7", 0, 0, 7, 1'b1, 1'b0);
        tstep("s6.again6", 0, 0, 6, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Whole directed sequence is a few hundred cycles; this bound only guards a hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/bird_physics.md
# bird_physics

Vertical-motion engine for the Flappy Bird game. It consumes the one-cycle flap pulse produced by the player-input debouncer/edge detector and maintains the bird's row on the LED matrix. It applies a timed rise after each flap and gravity otherwise, and detects ceiling, floor and external collisions. Its row, state flags and physics tick strobe feed the display driver and the pipe-scroll logic.

## Interface

Parameters:
- ROWS, 16: matrix height; row 0 is the top, row ROWS-1 is the bottom.
- TICK_DIV, 4: clock cycles per physics step; must be at least 2.
- FLAP_RISE, 3: rows risen per flap; must be at least 1.
- START_ROW, 8: bird row in IDLE and after reset; must be less than ROWS.

Ports:
- clk, input, 1: system clock; single clock domain.
- reset, input, 1: synchronous, active-high; clears all state on the next posedge clk.
- flap, input, 1: one-cycle press pulse from the input stage; already synchronized.
- collide, input, 1: level from the pipe logic; bird overlaps a pipe.
- bird_row, output, $clog2(ROWS): current bird row.
- playing, output, 1: high in FLY.
- game_over, output, 1: high in DEAD.
- tick, output, 1: physics step strobe; high for one cycle per step in FLY only.

## Operation

- States are IDLE, FLY and DEAD; 2-bit encoding.
- Internal registers:
  - tcnt: tick counter, $clog2(TICK_DIV) bits.
  - rise: rows left to rise, $clog2(FLAP_RISE+1) bits.
  - bird_row.
- Reset values: state=IDLE, bird_row=START_ROW, tcnt=0, rise=0. As a result playing=0, game_over=0, tick=0.
- IDLE:
  - bird_row holds START_ROW and collide is ignored.
  - flap causes state<=FLY, rise<=FLAP_RISE, tcnt<=0.
- FLY:
  - tcnt increments every cycle and wraps from TICK_DIV-1 to 0.
  - tick = (state==FLY) && (tcnt==TICK_DIV-1). This is combinational from registers.
  - flap without tick reloads rise<=FLAP_RISE. Flaps reload rise; they never accumulate.
  - On a tick cycle, evaluate with effective rise r' = flap ? FLAP_RISE : rise:
    - If r'>0 and bird_row==0: state<=DEAD (ceiling); bird_row holds.
    - If r'>0 and bird_row>0: bird_row<=bird_row-1 and rise<=r'-1.
    - If r'==0 and bird_row==ROWS-1: state<=DEAD (floor); bird_row holds.
    - If r'==0 otherwise: bird_row<=bird_row+1.
  - collide has the highest priority. collide=1 in any FLY cycle gives state<=DEAD with no movement that edge, even when tick and flap are also high.
- DEAD:
  - bird_row, tcnt and rise are frozen.
  - flap and collide are ignored.
  - Only reset leaves DEAD.
- Reset has priority over every other input, including mid-FLY and in DEAD.
- Row arithmetic is unsigned. Bounds are checked before the update, so bird_row never wraps.

## Timing

- flap in IDLE at edge n: playing=1 after edge n. The first tick occurs TICK_DIV cycles after entering FLY, i.e. the FLY cycle with tcnt==TICK_DIV-1.
- tick is asserted in the same cycle the row update is computed. The new bird_row is visible after the following edge (1-cycle latency).
- collide sampled at edge n: game_over=1 and playing=0 after edge n.
- Ceiling or floor death occurs at the tick edge that would have moved the bird out of range.
- tick period in FLY is exactly TICK_DIV cycles; there is no tick in IDLE or DEAD.

## Test plan

Bench parameters: ROWS=16, TICK_DIV=4, FLAP_RISE=3, START_ROW=8.

1. Reset: assert reset for 2 cycles -> bird_row=8, playing=0, game_over=0, tick=0; flap held low keeps IDLE with no ticks for 20 cycles.
2. Single flap: one flap pulse in IDLE -> playing=1 next cycle; tick every 4th cycle; bird_row sequence 8,7,6,5,6,7,...,15; the next tick after 15 gives game_over=1 with bird_row stuck at 15.
3. Reload and simultaneous events: flap at the row-6 step, then flap coincident with a tick at row 5 -> rise reloads each time (no accumulation); bird_row 5->4 on that tick, then rises to 2 before falling.
4. Ceiling: drive row to 1 with rise pending -> 1->0, then the next rising tick sets game_over=1 and bird_row stays 0.
5. Collision: 1-cycle collide at row 7 in FLY, coincident with tick and flap -> game_over=1 next cycle, bird_row=7 frozen; later flaps and collide pulses cause no change and no tick.
6. Reset mid-operation: reset in FLY at row 11 and again in DEAD -> IDLE, bird_row=8, tcnt=0 next cycle; a new flap restarts the sequence from item 2.
